// File: rtl/mcu_subsys_pkg.sv
// Shared types and constants for the MCU subsystem peripheral bridge.
package mcu_subsys_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } bridge_state_t;

    localparam logic [31:0] PERIPH_BASE_DEFAULT = 32'h0200_0000;
    localparam logic [31:0] ERR_WORD            = 32'hDEAD_BEEF;

    // Slot field value that selects the bridge's own register block
    localparam logic [3:0]  INT_REGION     = 4'hF;

    localparam logic [11:0] OFS_ERR_STATUS = 12'h000;
    localparam logic [11:0] OFS_ERR_ADDR   = 12'h004;
    localparam logic [11:0] OFS_ERR_COUNT  = 12'h008;

endpackage

// File: rtl/mcu_subsys_periph_bridge_regs.sv
// Error status / address / count registers of the peripheral bridge.
module mcu_subsys_periph_bridge_regs
    import mcu_subsys_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [11:0] offset,
    input  logic [1:0]  wdata,
    input  logic        wstrb0,
    input  logic        ev_timeout,
    input  logic        ev_decode,
    input  logic [31:0] ev_addr,
    output logic [31:0] rdata
);

    logic [1:0]  status;
    logic [31:0] err_addr;
    logic [15:0] count;
    logic [1:0]  status_cleared;

    // Status value left behind by a W1C write
    always_comb begin
        status_cleared = status & ~(wdata & {2{wstrb0}});
    end

    // Sticky flags, first-error address and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status   <= '0;
            err_addr <= '0;
            count    <= '0;
        end else if (wr_en) begin
            if (offset == OFS_ERR_STATUS) begin
                status <= status_cleared;
                if (status_cleared == 2'b00) begin
                    count <= '0;
                end
            end
        end else if (ev_timeout || ev_decode) begin
            status <= status | {ev_decode, ev_timeout};
            if (status == 2'b00) begin
                err_addr <= ev_addr;
            end
            if (count != 16'hFFFF) begin
                count <= count + 16'd1;
            end
        end
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rdata = '0;
        case (offset)
            OFS_ERR_STATUS: rdata = {30'd0, status};
            OFS_ERR_ADDR:   rdata = err_addr;
            OFS_ERR_COUNT:  rdata = {16'd0, count};
            default:        rdata = '0;
        endcase
    end

endmodule

// File: rtl/mcu_subsys_periph_bridge.sv
// CPU-to-peripheral bridge: address decode, access FSM and bus timeout.
module mcu_subsys_periph_bridge
    import mcu_subsys_pkg::*;
#(
    parameter int          NUM_SLOTS      = 4,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] PERIPH_BASE    = PERIPH_BASE_DEFAULT
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    periph_mem_valid,
    output logic                    periph_mem_ready,
    input  logic [31:0]             periph_mem_addr,
    input  logic [31:0]             periph_mem_wdata,
    input  logic [3:0]              periph_mem_wstrb,
    output logic [31:0]             periph_mem_rdata,
    output logic [NUM_SLOTS-1:0]    slv_sel,
    output logic [11:0]             slv_addr,
    output logic [31:0]             slv_wdata,
    output logic [3:0]              slv_wstrb,
    input  logic [NUM_SLOTS-1:0]    slv_ready,
    input  logic [NUM_SLOTS*32-1:0] slv_rdata
);

    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]  SLOTS_NUM = 5'(NUM_SLOTS);

    bridge_state_t        state;
    logic [15:0]          cnt;
    logic [31:0]          addr_q;
    logic                 hit_base, is_slot, is_int, is_err;
    logic [NUM_SLOTS-1:0] dec_sel;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;
    logic [31:0]          regs_rdata;
    logic                 accept, int_wr, ev_timeout, ev_decode;
    logic [31:0]          ev_addr;

    // Address decode of the live request
    always_comb begin
        hit_base = (periph_mem_addr[31:16] == PERIPH_BASE[31:16]);
        is_slot  = hit_base && ({1'b0, periph_mem_addr[15:12]} < SLOTS_NUM);
        is_int   = hit_base && (periph_mem_addr[15:12] == INT_REGION);
        is_err   = !is_slot && !is_int;
        dec_sel  = NUM_SLOTS'(1) << periph_mem_addr[15:12];
    end

    // Select only the active slot's ready/rdata; others are masked by slv_sel
    always_comb begin
        sel_ready = |(slv_ready & slv_sel);
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slv_sel[i]) begin
                sel_rdata = sel_rdata | slv_rdata[i*32 +: 32];
            end
        end
    end

    // Error events and internal register write strobe
    always_comb begin
        accept     = (state == ST_IDLE) && periph_mem_valid;
        int_wr     = accept && is_int && (periph_mem_wstrb != 4'b0000);
        ev_decode  = accept && is_err;
        ev_timeout = (state == ST_ACCESS) && !sel_ready && (cnt == CNT_LAST);
        ev_addr    = ev_timeout ? addr_q : periph_mem_addr;
    end

    mcu_subsys_periph_bridge_regs u_regs (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .wr_en      (int_wr),
        .offset     (periph_mem_addr[11:0]),
        .wdata      (periph_mem_wdata[1:0]),
        .wstrb0     (periph_mem_wstrb[0]),
        .ev_timeout (ev_timeout),
        .ev_decode  (ev_decode),
        .ev_addr    (ev_addr),
        .rdata      (regs_rdata)
    );

    // Access FSM with registered CPU and slave-side outputs
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            addr_q           <= '0;
            periph_mem_ready <= 1'b0;
            periph_mem_rdata <= '0;
            slv_sel          <= '0;
            slv_addr         <= '0;
            slv_wdata        <= '0;
            slv_wstrb        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    periph_mem_ready <= 1'b0;
                    periph_mem_rdata <= '0;
                    if (periph_mem_valid) begin
                        addr_q <= periph_mem_addr;
                        if (is_slot) begin
                            state     <= ST_ACCESS;
                            cnt       <= '0;
                            slv_sel   <= dec_sel;
                            slv_addr  <= periph_mem_addr[11:0];
                            slv_wdata <= periph_mem_wdata;
                            slv_wstrb <= periph_mem_wstrb;
                        end else begin
                            state            <= ST_RESP;
                            periph_mem_ready <= 1'b1;
                            periph_mem_rdata <= is_int ? regs_rdata : ERR_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready || cnt == CNT_LAST) begin
                        state            <= ST_RESP;
                        periph_mem_ready <= 1'b1;
                        periph_mem_rdata <= sel_ready ? sel_rdata : ERR_WORD;
                        cnt              <= '0;
                        slv_sel          <= '0;
                        slv_addr         <= '0;
                        slv_wdata        <= '0;
                        slv_wstrb        <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    state            <= ST_IDLE;
                    periph_mem_ready <= 1'b0;
                    periph_mem_rdata <= '0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mcu_subsys_periph_bridge.md
MCU_SUBSYS_PERIPH_BRIDGE -- requirements
Module: mcu_subsys_periph_bridge

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of downstream peripheral slots (1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256, cycles in ACCESS before a bus timeout (2..65535).
REQ-003 SHALL have parameter PERIPH_BASE, default 32'h0200_0000, base of the 64 KiB peripheral window.
REQ-004 SHALL have one clock and an asynchronous active-low reset: sys_clk  input  1  system clock; rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have periph_mem_valid  input  1  CPU-side request valid.
REQ-006 SHALL have periph_mem_ready  output  1  CPU-side completion, one-cycle pulse.
REQ-007 SHALL have periph_mem_addr  input  32, periph_mem_wdata  input  32, periph_mem_wstrb  input  4 (all zero = read).
REQ-008 SHALL have periph_mem_rdata  output  32  read data, valid while periph_mem_ready is high.
REQ-009 SHALL have slv_sel  output  NUM_SLOTS  one-hot slot select, held for the whole access.
REQ-010 SHALL have slv_addr  output  12  byte offset within slot; slv_wdata  output  32; slv_wstrb  output  4.
REQ-011 SHALL have slv_ready  input  NUM_SLOTS  per-slot completion; slv_rdata  input  NUM_SLOTS x 32  per-slot read data.

Function
REQ-012 SHALL decode: addr[31:16]==PERIPH_BASE[31:16] and addr[15:12]<NUM_SLOTS -> slot addr[15:12]; addr[15:12]==4'hF -> internal registers; anything else -> decode error.
REQ-013 SHALL implement FSM IDLE, ACCESS, RESP; reset state IDLE.
REQ-014 IDLE: on periph_mem_valid, SHALL register addr/wdata/wstrb and decode; slot hit -> ACCESS; internal or decode error -> RESP.
REQ-015 ACCESS: SHALL drive slv_sel one-hot and slv_addr/wdata/wstrb from the registered request; slv_sel SHALL be low in IDLE and RESP.
REQ-016 ACCESS: when slv_ready[slot] is high, SHALL capture slv_rdata[slot] and go to RESP; slv_ready of unselected slots SHALL be ignored.
REQ-017 ACCESS: cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYCLES-1 without slv_ready -> timeout, rdata=32'hDEAD_BEEF, RESP; slv_ready in that same cycle SHALL take priority over timeout.
REQ-018 RESP: SHALL assert periph_mem_ready for exactly one cycle with registered rdata, then IDLE; periph_mem_rdata SHALL be 0 when ready is low.
REQ-019 Latency: zero-wait slot read/write -> ready 2 cycles after valid sampled; internal-register or decode-error access -> 1 cycle.
REQ-020 Decode error: write SHALL be dropped, read returns 32'hDEAD_BEEF, ready still returned.
REQ-021 Internal 0xF000 ERR_STATUS: bit0 timeout sticky, bit1 decode-error sticky; write with wstrb[0] and data bit=1 clears that bit (W1C).
REQ-022 Internal 0xF004 ERR_ADDR: read-only, latches full address of the first error while ERR_STATUS==0.
REQ-023 Internal 0xF008 ERR_COUNT: read-only, 16-bit, increments per error, saturates at 16'hFFFF, cleared when a W1C write leaves ERR_STATUS==0.
REQ-024 Other internal offsets SHALL read 0 and ignore writes, not flagged as errors.
REQ-025 SHALL accept a new request in the first IDLE cycle after RESP (CPU deasserts valid after the handshake).

Reset
REQ-026 On rst_n low, SHALL immediately force IDLE, periph_mem_ready=0, periph_mem_rdata=0, slv_sel=0, slv_addr/wdata/wstrb=0, counter=0, ERR_STATUS/ERR_ADDR/ERR_COUNT=0, including mid-access.
REQ-027 After reset release, first request SHALL be accepted no earlier than the first rising edge with rst_n high.

Structure
REQ-028 mcu_subsys_pkg SHALL hold the FSM state enum, PERIPH_BASE default, error word 32'hDEAD_BEEF and internal register offsets.
REQ-029 Error registers SHALL live in sub-module mcu_subsys_periph_bridge_regs; decode, FSM and timeout in the top.

Verification
REQ-030 Read addr 32'h0200_1010, slv_ready[1] same cycle as sel, rdata 32'h1234_5678 -> slv_sel=4'b0010, slv_addr=12'h010, ready 2 cycles after valid, rdata 32'h1234_5678.
REQ-031 Write 32'h0200_0004 wdata 32'hA5A5_A5A5 wstrb 4'b0011, slot 0 ready after 5 cycles -> slv_wstrb=4'b0011 held 5 cycles, ready 1 cycle later.
REQ-032 Read slot 2, never ready, TIMEOUT_CYCLES=16 -> ready after 16 ACCESS cycles, rdata 32'hDEAD_BEEF, ERR_STATUS=1, ERR_ADDR=32'h0200_2000, ERR_COUNT=1.
REQ-033 Write 32'h0200_5000 (NUM_SLOTS=4) -> no slv_sel, ready 1 cycle, ERR_STATUS bit1; write 32'h3 to 0x0200_F000 -> ERR_STATUS=0, ERR_COUNT=0.
REQ-034 Assert rst_n low during ACCESS -> slv_sel=0 and ready=0 same cycle; next request after release completes normally.
